// File: rtl/fetch_pkg.sv
// Shared types and constants for the barrel-thread fetch stage.
package fetch_pkg;

   localparam int unsigned NUM_THREADS      = 8;
   localparam int unsigned BITS_THREADS     = $clog2(NUM_THREADS);

   typedef logic [BITS_THREADS-1:0] tid_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC         = 32'h0000_0000;
   localparam logic [31:0] THREAD_PC_STRIDE = 32'h0000_0400;

endpackage

// File: rtl/thread_rr_sel.sv
// Round-robin thread selector.
// Default build: strict rotation, sel is the pointer and an idle slot yields a bubble.
// FETCH_SKIP_IDLE_EN: priority rotation, sel is the first active thread at or after the pointer.
module thread_rr_sel #(
   parameter int unsigned NUM_THREADS  = 8,
   parameter int unsigned BITS_THREADS = 3
) (
   input  logic [BITS_THREADS-1:0] ptr_i,
   input  logic [NUM_THREADS-1:0]  active_i,
   input  logic                    stall_i,
   output logic [BITS_THREADS-1:0] sel_o,
   output logic                    sel_valid_o,
   output logic [BITS_THREADS-1:0] ptr_next_o
);

`ifdef FETCH_SKIP_IDLE_EN
   logic found;

   // Search the rotation starting at the pointer for the first active thread.
   always_comb begin : p_search
      logic [BITS_THREADS-1:0] cand;
      cand  = ptr_i;
      sel_o = ptr_i;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_THREADS; k++) begin
         cand = ptr_i + BITS_THREADS'(k);
         if (!found && active_i[cand]) begin
            sel_o = cand;
            found = 1'b1;
         end
      end
   end

   assign sel_valid_o = found;

   // Resume after the chosen thread; with nobody active keep rotating.
   always_comb begin
      ptr_next_o = ptr_i;
      if (!stall_i) begin
         ptr_next_o = found ? sel_o + BITS_THREADS'(1) : ptr_i + BITS_THREADS'(1);
      end
   end
`else
   assign sel_o       = ptr_i;
   assign sel_valid_o = active_i[ptr_i];

   // Fixed rotation: advance by one on every unstalled cycle, wrapping naturally.
   always_comb begin
      ptr_next_o = ptr_i;
      if (!stall_i) begin
         ptr_next_o = ptr_i + BITS_THREADS'(1);
      end
   end
`endif

endmodule

// File: rtl/barrel_thread_fetch.sv
// Per-thread PC file and thread scheduler feeding the F/D pipeline register.
// Optional feature macro: FETCH_SKIP_IDLE_EN (skip inactive threads in the selector).
module barrel_thread_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned NUM_THREADS   = 8,
   parameter int unsigned BITS_THREADS  = $clog2(NUM_THREADS),
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = ADDRESS_WIDTH'(fetch_pkg::RESET_PC),
   parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE =
      ADDRESS_WIDTH'(fetch_pkg::THREAD_PC_STRIDE)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_f,
   input  logic                     pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   input  logic [BITS_THREADS-1:0]  tid_e,
   input  logic                     halt_e,
   input  logic                     start_valid,
   input  logic [BITS_THREADS-1:0]  start_tid,
   input  logic [ADDRESS_WIDTH-1:0] start_pc,
   output logic                     imem_en,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   output logic                     valid_f,
   output logic [ADDRESS_WIDTH-1:0] pc_f,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
   output logic [DATA_WIDTH-1:0]    instr_f,
   output logic [BITS_THREADS-1:0]  tid_f,
   output logic [NUM_THREADS-1:0]   active_mask
);

   logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [NUM_THREADS-1:0]   active_q, active_d;
   logic [BITS_THREADS-1:0]  ptr_q, ptr_d;

   logic                     f1_valid_q, f1_valid_d;
   logic [ADDRESS_WIDTH-1:0] f1_pc_q, f1_pc_d;
   logic [BITS_THREADS-1:0]  f1_tid_q, f1_tid_d;

   logic [BITS_THREADS-1:0]  sel;
   logic                     sel_valid;
   logic                     issue;
   logic                     squash;

   thread_rr_sel #(
      .NUM_THREADS  (NUM_THREADS),
      .BITS_THREADS (BITS_THREADS)
   ) u_sel (
      .ptr_i       (ptr_q),
      .active_i    (active_q),
      .stall_i     (stall_f),
      .sel_o       (sel),
      .sel_valid_o (sel_valid),
      .ptr_next_o  (ptr_d)
   );

   // No fetch is issued while reset is held or the downstream stage is holding.
   assign issue     = rst & sel_valid & ~stall_f;
   assign imem_en   = issue;
   assign imem_addr = pc_q[sel];

   // Kill whatever F1 holds when execute redirects or halts that same thread.
   assign squash    = (pc_src_e | halt_e) & (tid_e == f1_tid_q);

   // PC file update: start beats redirect, redirect beats the sequential +4.
   always_comb begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
         pc_d[t] = pc_q[t];
         if (issue && sel == BITS_THREADS'(t)) begin
            pc_d[t] = pc_q[t] + ADDRESS_WIDTH'(4);
         end
         if (pc_src_e && tid_e == BITS_THREADS'(t)) begin
            pc_d[t] = pc_target_e;
         end
         if (start_valid && start_tid == BITS_THREADS'(t)) begin
            pc_d[t] = start_pc;
         end
      end
   end

   // Active mask update: start wins over halt on the same thread.
   always_comb begin
      active_d = active_q;
      if (halt_e) begin
         active_d[tid_e] = 1'b0;
      end
      if (start_valid) begin
         active_d[start_tid] = 1'b1;
      end
   end

   // F1 register: load on issue, bubble on idle slot, hold on stall (but honour a squash).
   always_comb begin
      f1_valid_d = f1_valid_q;
      f1_pc_d    = f1_pc_q;
      f1_tid_d   = f1_tid_q;
      if (!stall_f) begin
         f1_valid_d = issue;
         if (issue) begin
            f1_pc_d  = pc_q[sel];
            f1_tid_d = sel;
         end
      end else if (squash) begin
         f1_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pc_q[t] <= RESET_PC + THREAD_PC_STRIDE * ADDRESS_WIDTH'(t);
         end
         active_q   <= '1;
         ptr_q      <= '0;
         f1_valid_q <= 1'b0;
         f1_pc_q    <= '0;
         f1_tid_q   <= '0;
      end else begin
         for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            pc_q[t] <= pc_d[t];
         end
         active_q   <= active_d;
         ptr_q      <= ptr_d;
         f1_valid_q <= f1_valid_d;
         f1_pc_q    <= f1_pc_d;
         f1_tid_q   <= f1_tid_d;
      end
   end

   // F/D outputs; instr is forced to NOP whenever the slot carries nothing real.
   always_comb begin
      valid_f     = f1_valid_q & ~squash;
      pc_f        = f1_pc_q;
      pc_plus4_f  = f1_pc_q + ADDRESS_WIDTH'(4);
      tid_f       = f1_tid_q;
      instr_f     = valid_f ? imem_rdata : DATA_WIDTH'(NOP_INSTR);
      active_mask = active_q;
   end

endmodule

// File: tb/tb_barrel_thread_fetch.sv
// Self-checking bench for barrel_thread_fetch (NUM_THREADS=8).
// Build with FETCH_SKIP_IDLE_EN defined to exercise the skip-idle selector.
module tb_barrel_thread_fetch;

   localparam int NT = 8;
`ifdef FETCH_SKIP_IDLE_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall_f, pc_src_e, halt_e, start_valid;
   logic [31:0] pc_target_e, start_pc;
   logic [2:0]  tid_e, start_tid;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        valid_f;
   logic [31:0] pc_f, pc_plus4_f, instr_f;
   logic [2:0]  tid_f;
   logic [7:0]  active_mask;

   int n_chk  = 0;
   int n_pass = 0;

   barrel_thread_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall_f     (stall_f),
      .pc_src_e    (pc_src_e),
      .pc_target_e (pc_target_e),
      .tid_e       (tid_e),
      .halt_e      (halt_e),
      .start_valid (start_valid),
      .start_tid   (start_tid),
      .start_pc    (start_pc),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .valid_f     (valid_f),
      .pc_f        (pc_f),
      .pc_plus4_f  (pc_plus4_f),
      .instr_f     (instr_f),
      .tid_f       (tid_f),
      .active_mask (active_mask)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: every address holds a distinct word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Synchronous imem: data appears one cycle after the enable and holds otherwise.
   always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc [NT];
   bit          m_act [NT];
   int          m_ptr;
   bit          m_f1v;
   logic [31:0] m_f1pc;
   int          m_f1tid;
   bit          model_ok = 1'b0;

   function automatic int model_sel();
      if (SKIP) begin
         for (int k = 0; k < NT; k++) if (m_act[(m_ptr + k) % NT]) return (m_ptr + k) % NT;
      end
      return m_ptr;
   endfunction

   function automatic bit any_active();
      for (int k = 0; k < NT; k++) if (m_act[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_squash();
      return (pc_src_e || halt_e) && (int'(tid_e) == m_f1tid);
   endfunction

   always @(posedge clk) begin
      int s;
      bit sq;
      if (!rst) begin
         for (int t = 0; t < NT; t++) begin
            m_pc[t]  = t * 32'h400;
            m_act[t] = 1'b1;
         end
         m_ptr = 0; m_f1v = 0; m_f1pc = 0; m_f1tid = 0;
         model_ok = 1'b1;
      end else begin
         s  = model_sel();
         sq = model_squash();
         if (!stall_f) begin
            if (m_act[s]) begin
               m_f1v = 1; m_f1pc = m_pc[s]; m_f1tid = s;
               m_pc[s] = m_pc[s] + 32'd4;
            end else begin
               m_f1v = 0;
            end
            m_ptr = (SKIP && any_active()) ? (s + 1) % NT : (m_ptr + 1) % NT;
         end else if (sq) begin
            m_f1v = 0;
         end
         if (pc_src_e)    m_pc[tid_e] = pc_target_e;
         if (halt_e)      m_act[tid_e] = 1'b0;
         if (start_valid) begin
            m_act[start_tid] = 1'b1;
            m_pc[start_tid]  = start_pc;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      bit   ev, een;
      int   s;
      logic [7:0] am;
      if (model_ok) begin
         ev = m_f1v && !model_squash();
         check("valid_f", {31'b0, valid_f}, {31'b0, ev});
         if (ev) begin
            check("pc_f", pc_f, m_f1pc);
            check("pc_plus4_f", pc_plus4_f, m_f1pc + 32'd4);
            check("tid_f", {29'b0, tid_f}, m_f1tid);
            check("instr_f", instr_f, mem_word(m_f1pc));
         end else begin
            check("instr_nop", instr_f, NOP);
         end
         s   = model_sel();
         een = rst && !stall_f && m_act[s];
         check("imem_en", {31'b0, imem_en}, {31'b0, een});
         if (een) check("imem_addr", imem_addr, m_pc[s]);
         for (int t = 0; t < NT; t++) am[t] = m_act[t];
         check("active_mask", {24'b0, active_mask}, {24'b0, am});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n4, lim;
      logic [31:0] h_pc, h_instr;
      logic [2:0]  h_tid;
      logic        h_v;
      rst = 0; stall_f = 0; pc_src_e = 0; halt_e = 0; start_valid = 0;
      pc_target_e = 0; start_pc = 0; tid_e = 0; start_tid = 0;

      // 1. reset values, then strict order 0..7 with stride PCs
      repeat (3) step();
      check("rst_valid", {31'b0, valid_f}, 32'd0);
      check("rst_pc", pc_f, 32'h0);
      check("rst_pc4", pc_plus4_f, 32'h4);
      check("rst_instr", instr_f, NOP);
      check("rst_tid", {29'b0, tid_f}, 32'd0);
      check("rst_en", {31'b0, imem_en}, 32'd0);
      check("rst_mask", {24'b0, active_mask}, 32'hFF);
      rst = 1;
      #1;
      check("rel_valid", {31'b0, valid_f}, 32'd0);
      check("rel_addr", imem_addr, 32'h0);
      for (int c = 1; c <= 16; c++) begin
         step();
         check("seq_valid", {31'b0, valid_f}, 32'd1);
         check("seq_tid", {29'b0, tid_f}, (c - 1) % 8);
         check("seq_pc", pc_f, ((c - 1) % 8) * 32'h400 + ((c - 1) / 8) * 4);
      end

      // 2. redirect thread 2 while thread 5 is being selected
      lim = 0;
      while (model_sel() != 5 && lim < 20) begin step(); lim++; end
      check("t2_sync", lim < 20, 1);
      pc_src_e = 1; tid_e = 2; pc_target_e = 32'h2000;
      step();
      pc_src_e = 0;
      lim = 0;
      while (!(valid_f && tid_f == 3'd2) && lim < 20) begin step(); lim++; end
      check("redir_wait", lim < 20, 1);
      check("redir_pc", pc_f, 32'h2000);
      check("redir_pc4", pc_plus4_f, 32'h2004);

      // 3. halt thread 4, confirm it never issues, restart at 0x80
      lim = 0;
      while (model_sel() != 0 && lim < 20) begin step(); lim++; end
      halt_e = 1; tid_e = 4;
      step();
      halt_e = 0;
      n4 = 0;
      for (int c = 0; c < 16; c++) begin
         if (valid_f && tid_f == 3'd4) n4++;
         step();
      end
      check("halt_no_t4", n4, 0);
      check("halt_mask", {24'b0, active_mask}, 32'hEF);
      start_valid = 1; start_tid = 4; start_pc = 32'h80;
      step();
      start_valid = 0;
      lim = 0;
      while (!(valid_f && tid_f == 3'd4) && lim < 20) begin step(); lim++; end
      check("start_wait", lim < 20, 1);
      check("start_pc", pc_f, 32'h80);

      // 4. three-cycle stall: outputs frozen, no fetch
      repeat (3) step();
      h_pc = pc_f; h_instr = instr_f; h_tid = tid_f; h_v = valid_f;
      stall_f = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall_pc", pc_f, h_pc);
         check("stall_instr", instr_f, h_instr);
         check("stall_tid", {29'b0, tid_f}, {29'b0, h_tid});
         check("stall_valid", {31'b0, valid_f}, {31'b0, h_v});
         check("stall_en", {31'b0, imem_en}, 32'd0);
      end
      stall_f = 0;
      repeat (10) step();

      // 5. skip mode: lone thread redirected while in F1; then all threads idle
      if (SKIP) begin
         for (int t = 0; t < NT; t++) begin
            if (t != 1) begin
               halt_e = 1; tid_e = 3'(t);
               step();
            end
         end
         halt_e = 0;
         repeat (4) step();
         lim = 0;
         while (!(valid_f && tid_f == 3'd1) && lim < 20) begin step(); lim++; end
         check("solo_wait", lim < 20, 1);
         pc_src_e = 1; tid_e = 1; pc_target_e = 32'h3000;
         #1;
         check("squash_valid", {31'b0, valid_f}, 32'd0);
         step();
         pc_src_e = 0;
         check("solo_en", {31'b0, imem_en}, 32'd1);
         check("solo_addr", imem_addr, 32'h3000);
         repeat (4) step();
      end
      for (int t = 0; t < NT; t++) begin
         halt_e = 1; tid_e = 3'(t);
         step();
      end
      halt_e = 0;
      step();
      for (int c = 0; c < 12; c++) begin
         check("idle_en", {31'b0, imem_en}, 32'd0);
         check("idle_valid", {31'b0, valid_f}, 32'd0);
         step();
      end
      for (int t = 0; t < NT; t++) begin
         start_valid = 1; start_tid = 3'(t); start_pc = t * 32'h100;
         step();
      end
      start_valid = 0;
      repeat (12) step();

      // 6. reset pulse with a redirect on the same edge
      rst = 0; pc_src_e = 1; tid_e = 3; pc_target_e = 32'h5000;
      step();
      rst = 1; pc_src_e = 0;
      #1;
      check("rst2_valid", {31'b0, valid_f}, 32'd0);
      check("rst2_mask", {24'b0, active_mask}, 32'hFF);
      check("rst2_addr", imem_addr, 32'h0);
      lim = 0;
      while (!(valid_f && tid_f == 3'd3) && lim < 20) begin step(); lim++; end
      check("rst2_wait", lim < 20, 1);
      check("rst2_t3_pc", pc_f, 32'hC00);
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
